// File: rtl/pipelined_wallace_multiplier.sv
// Three-stage Wallace-tree multiplier with valid/ready flow control.
// S1 holds the partial-product matrix, S2 holds the carry-save pair, and S3 holds the final product.
module pipelined_wallace_multiplier #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int P  = 2 * WIDTH;
  localparam int NR = WIDTH + 1;  // WIDTH rows plus the +1 row that completes the negation
  localparam int NA = NR + 3;     // scratch depth so 3-row groups never index past the end

  typedef logic [P-1:0] row_t;
  typedef struct packed {
    row_t sum;
    row_t carry;
  } csa_t;

  // Wallace reduction: each layer compresses groups of three rows to two rows.
  // A group of three becomes sum and shifted carry. Any one or two rows left over pass straight through.
  // The layer count depends only on NR, so the loops unroll to a fixed tree.
  function automatic csa_t wallace(input row_t rows [NR]);
    row_t cur [NA];
    row_t nxt [NA];
    int   n;
    int   m;
    csa_t r;
    // NOTE: blocking assignments are correct here: each statement uses values computed earlier in the same evaluation.
    for (int i = 0; i < NA; i++) cur[i] = '0;
    for (int i = 0; i < NR; i++) cur[i] = rows[i];
    n = NR;
    for (int layer = 0; layer < NR; layer++) begin
      if (n > 2) begin
        for (int i = 0; i < NA; i++) nxt[i] = '0;
        m = 0;
        for (int g = 0; g < NA / 3; g++) begin
          if (3 * g + 2 < n) begin
            nxt[m]     = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
            nxt[m + 1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                          (cur[3*g+1] & cur[3*g+2])) << 1;
            m += 2;
          end else begin
            for (int k = 0; k < 2; k++) begin
              if (3 * g + k < n) begin
                nxt[m] = cur[3*g+k];
                m++;
              end
            end
          end
        end
        cur = nxt;
        n   = m;
      end
    end
    r.sum   = cur[0];
    r.carry = cur[1];
    return r;
  endfunction

  logic                 adv;
  logic                 v1_q, v2_q, v3_q;
  row_t                 pp_q [NR];
  row_t                 pp_d [NR];
  logic [TAG_W-1:0]     tag1_q, tag2_q, tag3_q;
  row_t                 sum_q, carry_q;
  csa_t                 red_d;
  row_t                 p_q;
  row_t                 a_ext;

  assign adv      = !v3_q | out_ready;
  assign in_ready = adv;

  // In signed mode the MSB row of in_b is subtracted.
  // Subtraction adds ~(a << (WIDTH-1)) here and a +1 in the extra row.
  always_comb begin
    a_ext = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
    for (int i = 0; i < NR; i++) pp_d[i] = '0;
    for (int i = 0; i < WIDTH - 1; i++) pp_d[i] = in_b[i] ? (a_ext << i) : '0;
    pp_d[WIDTH-1] = in_b[WIDTH-1] ?
                    (in_signed ? ~(a_ext << (WIDTH - 1)) : (a_ext << (WIDTH - 1))) : '0;
    pp_d[WIDTH]   = row_t'(in_signed & in_b[WIDTH-1]);
  end

  always_comb red_d = wallace(pp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are cleared as well, so out_p and out_tag read zero straight out of reset.
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      pp_q    <= '{default: '0};
      tag1_q  <= '0;
      tag2_q  <= '0;
      tag3_q  <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      p_q     <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      pp_q    <= pp_d;
      tag1_q  <= in_tag;
      v2_q    <= v1_q;
      sum_q   <= red_d.sum;
      carry_q <= red_d.carry;
      tag2_q  <= tag1_q;
      v3_q    <= v2_q;
      p_q     <= sum_q + carry_q;
      tag3_q  <= tag2_q;
    end
  end

  assign out_valid = v3_q;
  assign out_p     = p_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Scoreboard bench for pipelined_wallace_multiplier (WIDTH=8, TAG_W=4).
// The driver pushes the expected product on acceptance, and the monitor pops and compares on each output transfer.
module tb_pipelined_wallace_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic [3:0]  out_tag;

  pipelined_wallace_multiplier #(.WIDTH(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb [$];
  int   out_cycs [$];
  bit   rec_out = 1'b0;
  bit   chk_lat = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea;
    logic [15:0] eb;
    ea = s ? {{8{a[7]}}, a} : {8'h00, a};
    eb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return ea * eb;
  endfunction

  function automatic bit keep_b(input int b);
    return (b % 8 == 0) || (b < 8) || (b >= 248) || (b >= 120 && b <= 135);
  endfunction

  // The task is called just after a rising edge and returns just after the edge that accepted the operands.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [3:0] tag, input logic [15:0] exp);
    int guard = 0;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = tag;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) check("accept_timeout", in_ready, 1);
    sb.push_back('{p: exp, tag: tag, cyc: cyc, lat: chk_lat});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("product", {out_tag, out_p}, {e.tag, e.p});
        if (e.lat) check("latency", cyc - e.cyc, 3);
        if (rec_out) out_cycs.push_back(cyc);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p0;
    logic [3:0]  t0;
    int          cnt;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Most negative signed operands, with the latency checked.
    chk_lat = 1'b1;
    send(8'h80, 8'h80, 1'b1, 4'd1, 16'h4000);
    chk_lat = 1'b0;
    drain();

    // Corner operands in each mode.
    send(8'hFF, 8'hFF, 1'b0, 4'd2, 16'hFE01);
    send(8'hFF, 8'hFF, 1'b1, 4'd3, 16'h0001);
    send(8'hFF, 8'h7F, 1'b1, 4'd4, 16'hFF81);
    drain();

    // Back-to-back mixed-mode stream.
    rec_out = 1'b1;
    out_cycs.delete();
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom());
      b = 8'($urandom());
      s = 1'($urandom_range(0, 1));
      send(a, b, s, 4'(i), ref_mul(a, b, s));
    end
    drain();
    rec_out = 1'b0;
    check("stream_count", out_cycs.size(), 16);
    for (int i = 0; i < out_cycs.size(); i++) check("stream_gap", out_cycs[i] - out_cycs[0], i);

    // Backpressure: three operations fill the pipe, then a fourth waits while out_ready is low.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom());
      b = 8'($urandom());
      s = 1'($urandom_range(0, 1));
      send(a, b, s, 4'(8 + i), ref_mul(a, b, s));
    end
    a = 8'h5A; b = 8'hA5; s = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = 4'd11;
    @(negedge clk);
    p0 = out_p;
    t0 = out_tag;
    check("stall_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_hold", {out_tag, out_p}, {t0, p0});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(a, b, s, 4'd11, ref_mul(a, b, s));
    drain();

    // Reset with three operations in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(17 * i + 3), 8'(29 * i + 7), 1'b0, 4'(12 + i), 16'h0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("postrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send(8'h9C, 8'h3B, 1'b1, 4'd15, ref_mul(8'h9C, 8'h3B, 1'b1));
    chk_lat = 1'b0;
    drain();

    // Operand sweep: every a against boundary and strided b values, in both modes.
    cnt = 0;
    for (int sm = 0; sm < 2; sm++) begin
      for (int ia = 0; ia < 256; ia++) begin
        for (int ib = 0; ib < 256; ib++) begin
          if (keep_b(ib)) begin
            send(8'(ia), 8'(ib), 1'(sm), 4'(cnt), ref_mul(8'(ia), 8'(ib), 1'(sm)));
            cnt++;
          end
        end
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
